// File: rtl/display_seg_mux_if.sv
// Load-group bus for display_seg_mux.
// The producer (master) presents a new set of four BCD digits, decimal-point
// enables, blink mask and leading-zero-blank flag together with 'load'. The
// display (slave) answers with 'load_ready'. A load is taken only while
// load_ready is high.
//   load        : request to capture the load group
//   load_ready  : high when a load is accepted this cycle
//   digits_in   : four BCD nibbles, [3:0] = digit0 (rightmost)
//   dp_in       : decimal-point enables, bit n for digit n
//   blink_mask  : bit n set = digit n blinks
//   blank_lz    : leading-zero blanking enable
interface display_seg_mux_if;
  logic        load;
  logic        load_ready;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        blank_lz;

  modport master (
    output load, digits_in, dp_in, blink_mask, blank_lz,
    input  load_ready
  );

  modport slave (
    input  load, digits_in, dp_in, blink_mask, blank_lz,
    output load_ready
  );
endinterface

// File: rtl/display_seg_mux.sv
// Four-digit 7-segment display multiplexer.
// Holds a display register that is only updated at frame boundaries (m_sec
// tick while the scan FSM is on anode 3), so a new value never tears across
// a partially scanned frame. New values are staged in a one-deep pending
// register; load_ready is low while that stage is occupied.
//
// Optional feature: define DISPLAY_BLINK_EN to build the blink counter. Without
// it blink_mask is ignored and BLINK_DIV is unused.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   m_sec      : one-cycle 1 ms tick
//   anode_sel  : scan-FSM anode index 0..3
//   digit_sel  : scan-FSM digit index 0..3
//   load_bus   : load-group bus (slave side)
//   seg_n      : active-low segments, [0]=a .. [6]=g (registered)
//   dp_n       : active-low decimal point (registered)
//   an_n       : active-low anodes, one-hot-low or all high (registered)
//   frame_done : one-cycle pulse after each display-register update
module display_seg_mux #(
  parameter int BLINK_DIV = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_sec,
  input  logic [1:0]              anode_sel,
  input  logic [1:0]              digit_sel,
  display_seg_mux_if.slave        load_bus,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [3:0]              an_n,
  output logic                    frame_done
);

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz;
  } disp_t;

  disp_t pend_reg;
  disp_t disp_reg;
  logic  pending;
  logic  frame_edge;
  logic  xfer;
  logic  accept;

  logic [3:0] nib;
  logic [3:0] blank_vec;
  logic       blanked;
  logic       dp_bit;
  logic       hide_an;

  // Active-low patterns, bit 0 = segment a.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign frame_edge          = m_sec && (anode_sel == 2'd3);
  assign xfer                = frame_edge && pending;
  // Transfer has priority: a load arriving on a boundary with the stage empty
  // is staged and waits for the next boundary.
  assign accept              = load_bus.load && !pending;
  assign load_bus.load_ready = ~pending;

  // Stage 0: pending and display registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= 1'b0;
      pend_reg   <= '0;
      disp_reg   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= xfer;
      if (xfer) begin
        disp_reg <= pend_reg;
        pending  <= 1'b0;
      end else if (accept) begin
        pend_reg.digits <= load_bus.digits_in;
        pend_reg.dp     <= load_bus.dp_in;
        pend_reg.lz     <= load_bus.blank_lz;
        pending         <= 1'b1;
      end
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam logic [9:0] DIV_LAST = 10'(BLINK_DIV - 1);

  logic [9:0] blink_cnt;
  logic       blink_phase;
  logic [3:0] pend_blink;
  logic [3:0] disp_blink;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pend_blink  <= '0;
      disp_blink  <= '0;
    end else begin
      if (m_sec) begin
        if (blink_cnt == DIV_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 10'd1;
        end
      end
      if (xfer) begin
        disp_blink <= pend_blink;
      end else if (accept) begin
        pend_blink <= load_bus.blink_mask;
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (^load_bus.blink_mask) ^ (BLINK_DIV != 0);
`endif

  always_comb begin
    nib = disp_reg.digits[3:0];
    case (digit_sel)
      2'd0: nib = disp_reg.digits[3:0];
      2'd1: nib = disp_reg.digits[7:4];
      2'd2: nib = disp_reg.digits[11:8];
      2'd3: nib = disp_reg.digits[15:12];
      default: nib = disp_reg.digits[3:0];
    endcase

    // A zero is "leading" only if every digit to its left is also zero;
    // digit0 is always shown.
    blank_vec[3] = disp_reg.lz && (disp_reg.digits[15:12] == 4'd0);
    blank_vec[2] = blank_vec[3] && (disp_reg.digits[11:8] == 4'd0);
    blank_vec[1] = blank_vec[2] && (disp_reg.digits[7:4] == 4'd0);
    blank_vec[0] = 1'b0;

    blanked = blank_vec[digit_sel];
    dp_bit  = disp_reg.dp[digit_sel];

    hide_an = 1'b0;
`ifdef DISPLAY_BLINK_EN
    hide_an = blink_phase && disp_blink[digit_sel];
`endif
  end

  // Stage 1: registered segment/anode outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
      an_n  <= 4'hF;
    end else begin
      seg_n <= blanked ? 7'h7F : seg_decode(nib);
      dp_n  <= blanked | ~dp_bit;
      an_n  <= hide_an ? 4'hF : ~(4'b0001 << anode_sel);
    end
  end

endmodule

// File: tb/tb_display_seg_mux.sv
module tb_display_seg_mux;

  localparam int BLINK_DIV = 4;
`ifdef DISPLAY_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       m_sec;
  logic [1:0] anode_sel;
  logic [1:0] digit_sel;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic       frame_done;

  display_seg_mux_if bus();

  display_seg_mux #(.BLINK_DIV(BLINK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .m_sec      (m_sec),
    .anode_sel  (anode_sel),
    .digit_sel  (digit_sel),
    .load_bus   (bus),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   ms_ticks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and compare the DUT outputs with the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val({e.tag, ".seg"}, 32'(seg_n), 32'(e.seg));
      check_val({e.tag, ".an"},  32'(an_n),  32'(e.an));
      check_val({e.tag, ".dp"},  32'(dp_n),  32'(e.dp));
      check_val({e.tag, ".fd"},  32'(frame_done), 32'(e.fd));
    end
  endtask

  task automatic scan(input logic [1:0] a, input logic [1:0] d, input logic m,
                      input logic [6:0] s, input logic [3:0] an, input logic dp,
                      input logic fd, input string tag);
    exp_t e;
    anode_sel = a;
    digit_sel = d;
    m_sec     = m;
    e.tag = tag; e.seg = s; e.an = an; e.dp = dp; e.fd = fd;
    sb.push_back(e);
    tick();
    if (m) ms_ticks++;
    bus.load = 1'b0;
    m_sec    = 1'b0;
  endtask

  task automatic set_load(input logic [15:0] dig, input logic [3:0] dp,
                          input logic [3:0] mask, input logic lz);
    bus.digits_in  = dig;
    bus.dp_in      = dp;
    bus.blink_mask = mask;
    bus.blank_lz   = lz;
    bus.load       = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, ".seg"},   32'(seg_n), 32'h7F);
    check_val({tag, ".an"},    32'(an_n), 32'hF);
    check_val({tag, ".dp"},    32'(dp_n), 32'h1);
    check_val({tag, ".fd"},    32'(frame_done), 32'h0);
    check_val({tag, ".ready"}, 32'(bus.load_ready), 32'h1);
  endtask

  initial begin
    logic [3:0] exp_an;
    rst = 1'b0; m_sec = 1'b0; anode_sel = 2'd0; digit_sel = 2'd0;
    bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;
    bus.blink_mask = '0; bus.blank_lz = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;

    // Cleared display shows 0 on digit0.
    scan(2'd0, 2'd0, 1'b0, 7'h40, 4'hE, 1'b1, 1'b0, "first");

    // Mid-frame load: staged, display unchanged until boundary.
    set_load(16'h1234, 4'h0, 4'h0, 1'b0);
    scan(2'd1, 2'd1, 1'b0, 7'h40, 4'hD, 1'b1, 1'b0, "ld_mid");
    check_val("ready_low", 32'(bus.load_ready), 32'h0);
    scan(2'd3, 2'd3, 1'b0, 7'h40, 4'h7, 1'b1, 1'b0, "pre_bnd");
    set_load(16'h5678, 4'h0, 4'h0, 1'b0);
    scan(2'd2, 2'd2, 1'b0, 7'h40, 4'hB, 1'b1, 1'b0, "ign_ld");
    scan(2'd3, 2'd3, 1'b1, 7'h40, 4'h7, 1'b1, 1'b1, "bnd1");
    check_val("ready_high", 32'(bus.load_ready), 32'h1);
    scan(2'd3, 2'd3, 1'b0, 7'h79, 4'h7, 1'b1, 1'b0, "d3_1");
    scan(2'd2, 2'd2, 1'b0, 7'h24, 4'hB, 1'b1, 1'b0, "d2_2");
    scan(2'd1, 2'd1, 1'b0, 7'h30, 4'hD, 1'b1, 1'b0, "d1_3");
    scan(2'd0, 2'd0, 1'b0, 7'h19, 4'hE, 1'b1, 1'b0, "d0_4");
    scan(2'd0, 2'd2, 1'b0, 7'h24, 4'hE, 1'b1, 1'b0, "indep");

    // Load on a boundary with stage empty transfers at the next boundary.
    set_load(16'h0007, 4'b1001, 4'h0, 1'b1);
    scan(2'd3, 2'd3, 1'b1, 7'h79, 4'h7, 1'b1, 1'b0, "bnd_ld");
    scan(2'd3, 2'd3, 1'b0, 7'h79, 4'h7, 1'b1, 1'b0, "no_xfer");
    scan(2'd3, 2'd3, 1'b1, 7'h79, 4'h7, 1'b1, 1'b1, "bnd2");
    scan(2'd3, 2'd3, 1'b0, 7'h7F, 4'h7, 1'b1, 1'b0, "lz3");
    scan(2'd2, 2'd2, 1'b0, 7'h7F, 4'hB, 1'b1, 1'b0, "lz2");
    scan(2'd1, 2'd1, 1'b0, 7'h7F, 4'hD, 1'b1, 1'b0, "lz1");
    scan(2'd0, 2'd0, 1'b0, 7'h78, 4'hE, 1'b0, 1'b0, "lz0_dp");

    // Only the leading zero is blanked; an embedded zero is shown.
    set_load(16'h0508, 4'h0, 4'h0, 1'b1);
    scan(2'd0, 2'd0, 1'b0, 7'h78, 4'hE, 1'b0, 1'b0, "ld0508");
    scan(2'd3, 2'd3, 1'b1, 7'h7F, 4'h7, 1'b1, 1'b1, "bnd3");
    scan(2'd3, 2'd3, 1'b0, 7'h7F, 4'h7, 1'b1, 1'b0, "e_d3");
    scan(2'd2, 2'd2, 1'b0, 7'h12, 4'hB, 1'b1, 1'b0, "e_d2");
    scan(2'd1, 2'd1, 1'b0, 7'h40, 4'hD, 1'b1, 1'b0, "e_d1");
    scan(2'd0, 2'd0, 1'b0, 7'h00, 4'hE, 1'b1, 1'b0, "e_d0");

    // Non-BCD nibble shows blank segments.
    set_load(16'h0A09, 4'h0, 4'h0, 1'b0);
    scan(2'd1, 2'd1, 1'b0, 7'h40, 4'hD, 1'b1, 1'b0, "ld0A09");
    scan(2'd3, 2'd3, 1'b1, 7'h7F, 4'h7, 1'b1, 1'b1, "bnd4");
    scan(2'd3, 2'd3, 1'b0, 7'h40, 4'h7, 1'b1, 1'b0, "h_d3");
    scan(2'd2, 2'd2, 1'b0, 7'h7F, 4'hB, 1'b1, 1'b0, "hexA");
    scan(2'd0, 2'd0, 1'b0, 7'h10, 4'hE, 1'b1, 1'b0, "h_d0");

    // Reset with a pending load discards it.
    set_load(16'h9999, 4'hF, 4'h0, 1'b0);
    scan(2'd2, 2'd2, 1'b0, 7'h7F, 4'hB, 1'b1, 1'b0, "ld9999");
    #3;
    rst = 1'b0;
    #1;
    check_reset_vals("rst_pend");
    @(posedge clk);
    #1;
    rst = 1'b1;
    ms_ticks = 0;
    scan(2'd3, 2'd3, 1'b1, 7'h40, 4'h7, 1'b1, 1'b0, "rst_bnd");
    scan(2'd3, 2'd3, 1'b0, 7'h40, 4'h7, 1'b1, 1'b0, "rst_d3");

    // Blink on digit0 (ignored when the feature is not built).
    set_load(16'h0008, 4'h0, 4'b0001, 1'b0);
    scan(2'd0, 2'd0, 1'b0, 7'h40, 4'hE, 1'b1, 1'b0, "ld_blk");
    scan(2'd3, 2'd3, 1'b1, 7'h40, 4'h7, 1'b1, 1'b1, "bnd_blk");
    for (int i = 0; i < 16; i++) begin
      exp_an = (BLINK_ON && (((ms_ticks / BLINK_DIV) % 2) == 1)) ? 4'hF : 4'hE;
      scan(2'd0, 2'd0, 1'b1, 7'h00, exp_an, 1'b1, 1'b0, "blink");
    end

    // Asynchronous reset mid-sequence restores outputs without a clock edge.
    #3;
    rst = 1'b0;
    #1;
    check_reset_vals("rst_blk");
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
